mac_sequencer: RTL
==================

# mac_sequencer

Multi-cycle sequencer for the MACI instruction of the picoMIPS core. It computes acc_in + (op_a × op_b) in signed fixed point with a serial shift-and-add multiplier. While busy it stalls the program counter, then issues a one-cycle register write strobe with the result. It sits beside the instruction decoder: the decoder raises start on a MACI opcode, and this block holds the PC until the accumulate retires.

## Interface
Parameters:
- WIDTH, 8: operand, accumulator and result width in bits, two's complement.
- FRAC, 7: fractional bits of op_b (coefficient format Q(WIDTH-1-FRAC).FRAC). Legal range 0..WIDTH-1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a MAC; sampled only in IDLE or DONE.
- op_a  in  WIDTH  signed multiplicand; captured on accepted start.
- op_b  in  WIDTH  signed multiplier/coefficient; captured on accepted start.
- acc_in  in  WIDTH  signed accumulator value; captured on accepted start.
- stall  out  1  hold PC; combinational.
- busy  out  1  high in MUL and ACC states.
- done  out  1  one-cycle write strobe for the register file.
- result  out  WIDTH  signed accumulate result; registered.
- ovf  out  1  signed overflow of the final add; registered, valid with done.

## Operation
- States: IDLE, MUL, ACC, DONE. Reset forces IDLE and clears the bit counter and product register. It also sets result=0, done=0, ovf=0.
- **Start acceptance.** An accepted start in IDLE or DONE captures op_a, op_b and acc_in, clears the 2·WIDTH-bit product register, sets count=0 and moves to MUL.
- **Start ignored.** A start in MUL or ACC is ignored, with no queueing.
- **MUL state.** One bit of the captured op_b is processed per cycle, LSB first, using op_a sign-extended to 2·WIDTH and shifted left by count.
  - For bits 0..WIDTH-2: if the bit is 1, add the shifted op_a to product.
  - For bit WIDTH-1 (sign): if the bit is 1, subtract the shifted op_a from product.
  - After count=WIDTH-1, go to ACC. MUL lasts exactly WIDTH cycles regardless of operand values.
- **ACC state.**
  - slice = product[WIDTH-1+FRAC : FRAC]. This is truncation toward −∞, and the upper product bits are discarded (wrap).
  - sum = acc_in + slice, modulo 2^WIDTH.
  - result ← sum.
  - ovf ← 1 when both add operands have the same sign and the sign of sum differs; otherwise 0.
  - Next state is DONE.
- **DONE state.**
  - done=1 for this cycle.
  - Next state is MUL if start=1 (back-to-back), else IDLE.
- result and ovf hold their values until the next ACC state or reset.
- The stall equation is: stall = ~reset & ((state==IDLE & start) | state==MUL | state==ACC).
  - stall is low in DONE, so the PC advances on the DONE edge.
  - A start accepted in DONE does not raise stall in that cycle. The decoder only presents a new start after the PC has advanced.

## Timing
- An accepted start at cycle 0 produces MUL on cycles 1..WIDTH, ACC on cycle WIDTH+1 and DONE on cycle WIDTH+2. With WIDTH=8, done is high at cycle 10.
- stall is high on cycles 0..WIDTH+1 and low on cycle WIDTH+2.
- result and ovf become valid in the DONE cycle, registered at the end of ACC.
- done is a single-cycle pulse, except for back-to-back operations. These give one done pulse per operation, WIDTH+2 cycles apart.
- Reset mid-operation: at the next edge the block is in IDLE, done=0, result=0, ovf=0, and stall is 0 during the reset cycle. The captured operation is discarded.
- Reset and start in the same cycle: reset wins and the start is not accepted.

## Test plan
- **Integer multiply.** FRAC=0, op_a=3, op_b=5, acc_in=7 → done at cycle 10, result=22, ovf=0, stall high cycles 0..9.
- **Fixed-point coefficient.** FRAC=7, op_a=100, op_b=64 (0.5), acc_in=10 → result=60, ovf=0.
- **Sign handling and truncation.** FRAC=7, op_a=−3, op_b=64 → slice=−2. With acc_in=0 → result=−2 (0xFE).
- **Wrap and overflow.**
  - FRAC=7, op_a=−128, op_b=−128, acc_in=0 → slice 0x80, result=−128, ovf=0.
  - Then op_a=127, op_b=127 (FRAC=0), acc_in=127 → ovf=1.
- **Back-to-back and ignored start.**
  - Hold start high continuously → done pulses at cycles 10 and 20.
  - A start pulsed at cycle 4 only → ignored, a single done at cycle 10.
- **Reset mid-operation.** Assert reset at cycle 5 → IDLE next cycle, done never pulses, result=0. A new start then completes normally.

Source files
------------

// File: rtl/mac_sequencer.sv
// mac_sequencer: serial shift-and-add multiply-accumulate for the MACI
// instruction. Holds the PC while the product is built, then strobes the
// register-file write with the truncated, wrapped accumulate result.
module mac_sequencer #(
    parameter int WIDTH = 8,
    parameter int FRAC  = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] acc_in,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    count;
    logic [PW-1:0]    product;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc_reg;
    logic             accept;
    logic             last_bit;
    logic [PW-1:0]    shifted_a;
    logic [PW-1:0]    product_next;
    logic [WIDTH-1:0] slice;
    logic [WIDTH-1:0] sum;
    logic             sum_ovf;

    // State register; reset returns the sequencer to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the combinational handshake outputs.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        stall      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        last_bit   = (count == CW'(WIDTH - 1));
        case (state)
            IDLE: begin
                accept = start;
                stall  = start;
                if (start) begin
                    next_state = MUL;
                end
            end
            MUL: begin
                stall = 1'b1;
                busy  = 1'b1;
                if (last_bit) begin
                    next_state = ACC;
                end
            end
            ACC: begin
                stall      = 1'b1;
                busy       = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                accept     = start;
                next_state = start ? MUL : IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (reset) begin
            stall  = 1'b0;
            accept = 1'b0;
        end
    end

    // Multiplier step and accumulate datapath; the sign bit of op_b carries
    // negative weight, so that step subtracts instead of adds.
    always_comb begin
        shifted_a    = {{WIDTH{a_reg[WIDTH-1]}}, a_reg} << count;
        product_next = product;
        if (b_reg[count]) begin
            if (last_bit) begin
                product_next = product - shifted_a;
            end else begin
                product_next = product + shifted_a;
            end
        end
        slice   = product[FRAC +: WIDTH];
        sum     = acc_reg + slice;
        sum_ovf = (acc_reg[WIDTH-1] == slice[WIDTH-1]) &&
                  (sum[WIDTH-1] != acc_reg[WIDTH-1]);
    end

    // Operand capture, serial product accumulation and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            product <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            acc_reg <= '0;
            result  <= '0;
            ovf     <= 1'b0;
        end else begin
            if (accept) begin
                a_reg   <= op_a;
                b_reg   <= op_b;
                acc_reg <= acc_in;
                product <= '0;
                count   <= '0;
            end else if (state == MUL) begin
                product <= product_next;
                count   <= count + CW'(1);
            end
            if (state == ACC) begin
                result <= sum;
                ovf    <= sum_ovf;
            end
        end
    end

endmodule
